// File: rtl/riscv151_pkg.sv
// ----------------------------------------------------------------------------
// riscv151_pkg
// Shared constants for the RISC-V 151 core memory map and fetch path.
// Holds the default reset PC, the bubble instruction, the pc bits that pick
// the BIOS and IMEM regions, and the region enumeration used by the fetch
// unit and the data-side memory controllers.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv151_pkg;

  // Address of the first instruction fetched after reset (start of BIOS).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // addi x0, x0, 0 -- inserted wherever decode must see a bubble.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // pc bit that selects the BIOS region; it wins over the IMEM bit.
  localparam int BIOS_SEL_BIT_DEFAULT = 30;

  // pc bit that selects the IMEM region when the BIOS bit is clear.
  localparam int IMEM_SEL_BIT_DEFAULT = 28;

  // Memory region an address falls into.
  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'd0,
    REGION_BIOS     = 2'd1,
    REGION_IMEM     = 2'd2
  } region_e;

endpackage

// File: rtl/fetch_region_decode.sv
// ----------------------------------------------------------------------------
// fetch_region_decode
// Combinational address-region decoder for the RISC-V 151 memory map.
// The BIOS select bit takes priority; the IMEM select bit only counts when
// the BIOS bit is clear. Anything else is unmapped.
// Ports:
//   pc        in  32  address to classify
//   is_bios   out 1   address lies in the BIOS region
//   is_imem   out 1   address lies in the IMEM region
//   unmapped  out 1   address lies in neither region
// ----------------------------------------------------------------------------
module fetch_region_decode
  import riscv151_pkg::*;
#(
  parameter int BIOS_SEL_BIT = BIOS_SEL_BIT_DEFAULT,
  parameter int IMEM_SEL_BIT = IMEM_SEL_BIT_DEFAULT
) (
  input  logic [31:0] pc,
  output logic        is_bios,
  output logic        is_imem,
  output logic        unmapped
);

  // Only two bits of the address matter; the reduction below keeps the
  // remaining bits formally consumed without affecting any output.
  logic unused_pc;
  assign unused_pc = ^pc;

  // Region classification. BIOS has priority so that the IMEM bit is ignored
  // for any BIOS address, and unmapped is simply "neither of the two".
  always_comb begin
    is_bios  = pc[BIOS_SEL_BIT];
    is_imem  = !pc[BIOS_SEL_BIT] && pc[IMEM_SEL_BIT];
    unmapped = !is_bios && !is_imem;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// riscv_fetch_unit
// Instruction-fetch front end for the RISC-V 151 core. Owns the fetch PC,
// drives the synchronous-read BIOS and IMEM address ports with the *next* pc
// so the data for the current pc is on dout one cycle later, selects the
// returned word by region and loads the decode pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold fetch pc and decode register
//   redirect_valid/_pc       taken branch/jump from execute and its target
//   imem_addr / imem_dout    IMEM port B word address / read data
//   bios_addr / bios_dout    BIOS port A word address / read data
//   fetch_pc                 current fetch pc
//   d_inst, d_pc,
//   d_pc_plus_4, d_valid     decode-stage register contents
//   fault_region             sticky: an unmapped pc reached decode
//   fault_misaligned         sticky: a redirect target had low bits set
// ----------------------------------------------------------------------------
module riscv_fetch_unit
  import riscv151_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W  = 14,
  parameter int          BIOS_ADDR_W  = 12,
  parameter int          BIOS_SEL_BIT = BIOS_SEL_BIT_DEFAULT,
  parameter int          IMEM_SEL_BIT = IMEM_SEL_BIT_DEFAULT,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_dout,
  output logic [BIOS_ADDR_W-1:0] bios_addr,
  input  logic [31:0]            bios_dout,
  output logic [31:0]            fetch_pc,
  output logic [31:0]            d_inst,
  output logic [31:0]            d_pc,
  output logic [31:0]            d_pc_plus_4,
  output logic                   d_valid,
  output logic                   fault_region,
  output logic                   fault_misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus_4;
  logic [31:0] d_inst_q, d_inst_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc_plus_4_q, d_pc_plus_4_d;
  logic        d_valid_q, d_valid_d;
  logic        fault_region_q, fault_region_d;
  logic        fault_misaligned_q, fault_misaligned_d;

  logic        is_bios, is_imem, unmapped;
  region_e     region;
  logic [31:0] fetch_inst;

  assign pc_plus_4 = pc_q + 32'd4;

  // Next-pc selection. Reset beats redirect beats stall beats sequential.
  // The result feeds both the pc register and the BRAM address ports, so
  // during a stall the same address is re-presented and dout stays stable.
  always_comb begin
    pc_d = pc_plus_4;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  assign imem_addr = pc_d[IMEM_ADDR_W+1:2];
  assign bios_addr = pc_d[BIOS_ADDR_W+1:2];

  fetch_region_decode #(
    .BIOS_SEL_BIT (BIOS_SEL_BIT),
    .IMEM_SEL_BIT (IMEM_SEL_BIT)
  ) u_region (
    .pc       (pc_q),
    .is_bios  (is_bios),
    .is_imem  (is_imem),
    .unmapped (unmapped)
  );

  // Collapse the decoder flags into a region tag and pick the word returned
  // for the current fetch pc. Unmapped fetches yield the bubble instruction.
  always_comb begin
    region = REGION_UNMAPPED;
    if (is_bios) begin
      region = REGION_BIOS;
    end else if (is_imem) begin
      region = REGION_IMEM;
    end

    fetch_inst = NOP_INST;
    case (region)
      REGION_BIOS:     fetch_inst = bios_dout;
      REGION_IMEM:     fetch_inst = imem_dout;
      default:         fetch_inst = NOP_INST;
    endcase
  end

  // Decode register and sticky fault flags. A redirect squashes the
  // wrong-path word even when stalled; a stall freezes everything; an
  // unmapped fetch becomes a bubble but still records its pc so the fault
  // can be traced. The region fault only sets when that bubble actually
  // enters decode (not stalled, not squashed).
  always_comb begin
    d_inst_d           = d_inst_q;
    d_pc_d             = d_pc_q;
    d_pc_plus_4_d      = d_pc_plus_4_q;
    d_valid_d          = d_valid_q;
    fault_region_d     = fault_region_q;
    fault_misaligned_d = fault_misaligned_q;

    if (redirect_valid) begin
      d_inst_d      = NOP_INST;
      d_pc_d        = pc_q;
      d_pc_plus_4_d = pc_plus_4;
      d_valid_d     = 1'b0;
    end else if (stall) begin
      d_inst_d      = d_inst_q;
    end else if (unmapped) begin
      d_inst_d       = NOP_INST;
      d_pc_d         = pc_q;
      d_pc_plus_4_d  = pc_plus_4;
      d_valid_d      = 1'b0;
      fault_region_d = 1'b1;
    end else begin
      d_inst_d      = fetch_inst;
      d_pc_d        = pc_q;
      d_pc_plus_4_d = pc_plus_4;
      d_valid_d     = 1'b1;
    end

    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_misaligned_d = 1'b1;
    end
  end

  // State registers with synchronous reset. Reset overrides stall and
  // redirect and returns every output to its idle value in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      d_inst_q           <= NOP_INST;
      d_pc_q             <= 32'd0;
      d_pc_plus_4_q      <= 32'd0;
      d_valid_q          <= 1'b0;
      fault_region_q     <= 1'b0;
      fault_misaligned_q <= 1'b0;
    end else begin
      pc_q               <= pc_d;
      d_inst_q           <= d_inst_d;
      d_pc_q             <= d_pc_d;
      d_pc_plus_4_q      <= d_pc_plus_4_d;
      d_valid_q          <= d_valid_d;
      fault_region_q     <= fault_region_d;
      fault_misaligned_q <= fault_misaligned_d;
    end
  end

  assign fetch_pc         = pc_q;
  assign d_inst           = d_inst_q;
  assign d_pc             = d_pc_q;
  assign d_pc_plus_4      = d_pc_plus_4_q;
  assign d_valid          = d_valid_q;
  assign fault_region     = fault_region_q;
  assign fault_misaligned = fault_misaligned_q;

endmodule
